// File: rtl/pet_if.sv
// pet_if: button inputs and display/debug outputs of the pet game-logic stage
interface pet_if;
  logic btn_feed;
  logic btn_play;
  logic btn_sleep;
  logic [2:0] face;
  logic [2:0] icon;
  logic enable;
  logic [3:0] hunger;
  logic [3:0] energy;
  logic [3:0] happiness;
  modport master (output btn_feed, btn_play, btn_sleep, input face, icon, enable, hunger, energy, happiness);
  modport slave (input btn_feed, btn_play, btn_sleep, output face, icon, enable, hunger, energy, happiness);
endinterface

// File: rtl/pet_state_engine.sv
// pet_state_engine: debounced buttons, tick timer and pet stat FSM feeding face/icon codes and a redraw request to the LCD drawer
module pet_state_engine #(
  parameter int TICK_DIV     = 25000000,
  parameter int DEBOUNCE_CYC = 250000,
  parameter int DECAY_TICKS  = 5,
  parameter int STAT_MAX     = 10,
  parameter int STARVE_TICKS = 8,
  parameter int ICON_TICKS   = 3,
  parameter int REDRAW_HOLD  = 65536
) (
  input logic clk,
  input logic reset,
  pet_if.slave io
);
  typedef enum logic [1:0] {AWAKE, SLEEPING, DEAD} state_t;
  localparam int TW = $clog2(TICK_DIV);
  localparam int DW = $clog2(DEBOUNCE_CYC + 1);
  localparam int KW = $clog2(DECAY_TICKS + 1);
  localparam int SW = $clog2(STARVE_TICKS + 1);
  localparam int IW = $clog2(ICON_TICKS + 1);
  localparam int HW = $clog2(REDRAW_HOLD + 1);
  localparam logic [3:0] SMAX = 4'(STAT_MAX);
  localparam logic [3:0] HIGH = 4'(STAT_MAX - 2);
  logic [2:0] raw, s1_q, s1_d, s2_q, s2_d, acc_q, acc_d, press, stable_end;
  logic [DW-1:0] deb_q [3];
  logic [DW-1:0] deb_d [3];
  logic [TW-1:0] tick_q, tick_d;
  logic [KW-1:0] dec_q, dec_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [IW-1:0] icnt_q, icnt_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [3:0] hunger_q, hunger_d, energy_q, energy_d, happy_q, happy_d;
  logic [2:0] act_q, act_d, face_q, face_d, icon_q, icon_d;
  logic first_q, first_d, tick, decay;
  state_t state_q, state_d;

  function automatic logic [3:0] sat_add(input logic [3:0] a, input logic [2:0] b);
    logic [4:0] s;
    s = {1'b0, a} + {2'b0, b};
    return s > {1'b0, SMAX} ? SMAX : s[3:0];
  endfunction

  function automatic logic [3:0] sat_sub(input logic [3:0] a, input logic [2:0] b);
    return a > {1'b0, b} ? a - {1'b0, b} : 4'd0;
  endfunction

  assign raw = {io.btn_sleep, io.btn_play, io.btn_feed};

  always_comb begin
    s1_d = raw;
    s2_d = s1_q;
    stable_end = '0;
    press = '0;
    acc_d = acc_q;
    for (int i = 0; i < 3; i++) begin
      stable_end[i] = s2_q[i] != acc_q[i] && deb_q[i] == DW'(DEBOUNCE_CYC - 1);
      deb_d[i] = (s2_q[i] == acc_q[i] || stable_end[i]) ? '0 : deb_q[i] + 1'b1;
      acc_d[i] = stable_end[i] ? s2_q[i] : acc_q[i];
      press[i] = stable_end[i] & s2_q[i];
    end
    tick = tick_q == TW'(TICK_DIV - 1);
    tick_d = tick ? '0 : tick_q + 1'b1;
    decay = tick && dec_q == KW'(DECAY_TICKS - 1);
    dec_d = decay ? '0 : tick ? dec_q + 1'b1 : dec_q;
    state_d = state_q;
    hunger_d = hunger_q;
    energy_d = energy_q;
    happy_d = happy_q;
    act_d = act_q;
    icnt_d = (tick && icnt_q != '0) ? icnt_q - 1'b1 : icnt_q;
    // decay lands first, the action then works on the decayed stats
    if (state_q == AWAKE) begin
      if (decay) begin
        hunger_d = sat_add(hunger_d, 3'd1);
        energy_d = sat_sub(energy_d, 3'd1);
        happy_d = sat_sub(happy_d, 3'd1);
      end
      if (press[2]) state_d = SLEEPING;
      else if (press[0]) begin
        hunger_d = sat_sub(hunger_d, 3'd3);
        act_d = 3'd1;
        icnt_d = IW'(ICON_TICKS);
      end else if (press[1]) begin
        happy_d = sat_add(happy_d, 3'd3);
        energy_d = sat_sub(energy_d, 3'd1);
        act_d = 3'd2;
        icnt_d = IW'(ICON_TICKS);
      end
      if (energy_d == 4'd0) state_d = SLEEPING;
    end else if (state_q == SLEEPING) begin
      if (decay) begin
        energy_d = sat_add(energy_d, 3'd2);
        hunger_d = sat_add(hunger_d, 3'd1);
      end
      if (press[2] || (decay && energy_d == SMAX)) state_d = AWAKE;
    end
    starve_d = state_q == DEAD ? starve_q : hunger_d != SMAX ? '0 : tick ? starve_q + 1'b1 : starve_q;
    if (state_q != DEAD && starve_d == SW'(STARVE_TICKS)) state_d = DEAD;
    if (state_d != AWAKE) icnt_d = '0;
    face_d = state_q == DEAD ? 3'd5 : state_q == SLEEPING ? 3'd3 : hunger_q >= HIGH ? 3'd4 :
             happy_q <= 4'd2 ? 3'd2 : happy_q >= HIGH ? 3'd0 : 3'd1;
    icon_d = state_q == DEAD ? 3'd5 : state_q == SLEEPING ? 3'd0 : icnt_q != '0 ? act_q :
             (hunger_q >= HIGH || energy_q <= 4'd2) ? 3'd4 : 3'd5;
    hold_d = (first_q || face_d != face_q || icon_d != icon_q) ? HW'(REDRAW_HOLD) :
             hold_q != '0 ? hold_q - 1'b1 : hold_q;
    first_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q <= '0;
      s2_q <= '0;
      acc_q <= '0;
      deb_q <= '{default: '0};
      tick_q <= '0;
      dec_q <= '0;
      state_q <= AWAKE;
      hunger_q <= '0;
      energy_q <= SMAX;
      happy_q <= 4'(STAT_MAX / 2);
      starve_q <= '0;
      icnt_q <= '0;
      act_q <= 3'd1;
      face_q <= 3'd1;
      icon_q <= 3'd5;
      hold_q <= '0;
      first_q <= 1'b1;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      acc_q <= acc_d;
      deb_q <= deb_d;
      tick_q <= tick_d;
      dec_q <= dec_d;
      state_q <= state_d;
      hunger_q <= hunger_d;
      energy_q <= energy_d;
      happy_q <= happy_d;
      starve_q <= starve_d;
      icnt_q <= icnt_d;
      act_q <= act_d;
      face_q <= face_d;
      icon_q <= icon_d;
      hold_q <= hold_d;
      first_q <= first_d;
    end
  end

  assign io.face = face_q;
  assign io.icon = icon_q;
  assign io.enable = hold_q != '0;
  assign io.hunger = hunger_q;
  assign io.energy = energy_q;
  assign io.happiness = happy_q;
endmodule
